// File: rtl/mssb_histogram.sv
// mssb_histogram: log2-magnitude histogram of an mssb-index sample stream.
// Collects 2**WINDOW_LOG2 accepted samples into N_BIN saturating bins.
// It then presents the bins one per ready/valid handshake and clears each
// bin as it is consumed, so the next window starts from zero.
module mssb_histogram #(
   parameter int N_BIN       = 8,
   parameter int CNT_W       = 8,
   parameter int WINDOW_LOG2 = 4,
   localparam int IDX_W      = (N_BIN > 1) ? $clog2(N_BIN) : 1
) (
   input  logic                   i_clk,
   input  logic                   i_arstn,
   input  logic                   i_cg,
   input  logic                   i_clear,
   input  logic                   i_smpValid,
   input  logic [IDX_W-1:0]       i_smpIndex,
   input  logic                   i_smpNonzero,
   output logic                   o_smpReady,
   output logic                   o_binValid,
   output logic [IDX_W-1:0]       o_binIndex,
   output logic [CNT_W-1:0]       o_binCount,
   output logic                   o_binLast,
   output logic [WINDOW_LOG2:0]   o_zeroCount,
   input  logic                   i_binReady
);

   typedef enum logic {
      ACCUM = 1'b0,
      DUMP  = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0] TOP_BIN     = IDX_W'(N_BIN - 1);
   localparam logic [IDX_W:0]   TOP_BIN_EXT = (IDX_W + 1)'(N_BIN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t                 state_q;
   state_t                 state_d;
   logic [CNT_W-1:0]       bin_q [N_BIN];
   logic [WINDOW_LOG2-1:0] win_cnt_q;
   logic [WINDOW_LOG2:0]   zero_cnt_q;
   logic [IDX_W-1:0]       ptr_q;

   logic                   do_clear;
   logic                   smp_acc;
   logic                   bin_hs;
   logic                   win_done;
   logic                   ptr_last;
   logic                   count_inc;
   logic [IDX_W-1:0]       smp_bin;

   // Event decode: clear outranks everything, and a gated clock kills all events.
   // The index compare is widened by one bit so the clamp test stays meaningful
   // even when N_BIN is a power of two and no index can exceed the top bin.
   always_comb begin
      do_clear = i_cg & i_clear;
      smp_acc  = i_cg & ~i_clear & i_smpValid & (state_q == ACCUM);
      bin_hs   = i_cg & ~i_clear & i_binReady & (state_q == DUMP);
      win_done = smp_acc & (win_cnt_q == {WINDOW_LOG2{1'b1}});
      ptr_last = (ptr_q == TOP_BIN);
      smp_bin  = i_smpIndex;
      if ({1'b0, i_smpIndex} > TOP_BIN_EXT) begin
         smp_bin = TOP_BIN;
      end
      count_inc = smp_acc & i_smpNonzero & (bin_q[smp_bin] != CNT_MAX);
   end

   // State register for the accumulate/dump sequence.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: the window-completing accept enters DUMP.
   // The handshake on the last bin returns to ACCUM.
   always_comb begin
      state_d = state_q;
      if (do_clear) begin
         state_d = ACCUM;
      end else begin
         case (state_q)
            ACCUM: if (win_done) state_d = DUMP;
            DUMP:  if (bin_hs && ptr_last) state_d = ACCUM;
            default: state_d = ACCUM;
         endcase
      end
   end

   // Bin counters: saturating increment while accumulating, clear-on-read while dumping.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         for (int b = 0; b < N_BIN; b++) begin
            bin_q[b] <= '0;
         end
      end else if (do_clear) begin
         for (int b = 0; b < N_BIN; b++) begin
            bin_q[b] <= '0;
         end
      end else if (count_inc) begin
         bin_q[smp_bin] <= bin_q[smp_bin] + CNT_W'(1);
      end else if (bin_hs) begin
         bin_q[ptr_q] <= '0;
      end
   end

   // The window counter wraps to zero on the completing accept.
   // It is also forced to zero at the end of the drain so the next window starts clean.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         win_cnt_q <= '0;
      end else if (do_clear) begin
         win_cnt_q <= '0;
      end else if (smp_acc) begin
         win_cnt_q <= win_cnt_q + WINDOW_LOG2'(1);
      end else if (bin_hs && ptr_last) begin
         win_cnt_q <= '0;
      end
   end

   // Zero-sample count: held through the dump so the consumer can read it alongside every bin.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         zero_cnt_q <= '0;
      end else if (do_clear) begin
         zero_cnt_q <= '0;
      end else if (smp_acc && !i_smpNonzero) begin
         zero_cnt_q <= zero_cnt_q + (WINDOW_LOG2 + 1)'(1);
      end else if (bin_hs && ptr_last) begin
         zero_cnt_q <= '0;
      end
   end

   // Drain pointer walks the bins once per handshake and wraps after the top bin.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         ptr_q <= '0;
      end else if (do_clear) begin
         ptr_q <= '0;
      end else if (bin_hs) begin
         ptr_q <= ptr_last ? '0 : ptr_q + IDX_W'(1);
      end
   end

   // Outputs come straight from registers.
   // The bin fields are forced to zero outside DUMP so idle outputs match reset.
   always_comb begin
      o_smpReady  = (state_q == ACCUM);
      o_binValid  = (state_q == DUMP);
      o_binIndex  = '0;
      o_binCount  = '0;
      o_binLast   = 1'b0;
      o_zeroCount = zero_cnt_q;
      if (state_q == DUMP) begin
         o_binIndex = ptr_q;
         o_binCount = bin_q[ptr_q];
         o_binLast  = ptr_last;
      end
   end

endmodule

// File: tb/tb_mssb_histogram.sv
// Testbench for mssb_histogram. A behavioural model fills a scoreboard queue whenever a
// window completes, and negedge monitors pop it on every bin handshake.
// A second instance (N_BIN=5, CNT_W=3) covers counter saturation and top-bin clamping.
module tb_mssb_histogram;

   typedef struct {
      int idx;
      int cnt;
      bit last;
      int zero;
   } exp_t;

   logic       clk = 1'b0;
   logic       arstn;
   logic       cg;
   logic       clear;
   logic       smp_valid;
   logic [2:0] smp_index;
   logic       smp_nonzero;
   logic       bin_ready;
   logic       smp_ready;
   logic       bin_valid;
   logic [2:0] bin_index;
   logic [7:0] bin_count;
   logic       bin_last;
   logic [4:0] zero_count;

   logic       cg2 = 1'b1;
   logic       clear2 = 1'b0;
   logic       smp_valid2;
   logic [2:0] smp_index2;
   logic       smp_nonzero2;
   logic       bin_ready2;
   logic       smp_ready2;
   logic       bin_valid2;
   logic [2:0] bin_index2;
   logic [2:0] bin_count2;
   logic       bin_last2;
   logic [4:0] zero_count2;

   int   n_compared = 0;
   int   n_mismatched = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e0;
   exp_t e1;
   int   m_bin[2][8];
   int   m_zero[2];
   int   m_win[2];

   always #5 clk = ~clk;

   mssb_histogram #(.N_BIN(8), .CNT_W(8), .WINDOW_LOG2(4)) dut (
      .i_clk(clk), .i_arstn(arstn), .i_cg(cg), .i_clear(clear),
      .i_smpValid(smp_valid), .i_smpIndex(smp_index), .i_smpNonzero(smp_nonzero),
      .o_smpReady(smp_ready), .o_binValid(bin_valid), .o_binIndex(bin_index),
      .o_binCount(bin_count), .o_binLast(bin_last), .o_zeroCount(zero_count),
      .i_binReady(bin_ready)
   );

   mssb_histogram #(.N_BIN(5), .CNT_W(3), .WINDOW_LOG2(4)) dut_sat (
      .i_clk(clk), .i_arstn(arstn), .i_cg(cg2), .i_clear(clear2),
      .i_smpValid(smp_valid2), .i_smpIndex(smp_index2), .i_smpNonzero(smp_nonzero2),
      .o_smpReady(smp_ready2), .o_binValid(bin_valid2), .o_binIndex(bin_index2),
      .o_binCount(bin_count2), .o_binLast(bin_last2), .o_zeroCount(zero_count2),
      .i_binReady(bin_ready2)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int nBins(input int sel);
      return (sel == 0) ? 8 : 5;
   endfunction

   function automatic int cntMax(input int sel);
      return (sel == 0) ? 255 : 7;
   endfunction

   task automatic resetModel(input int sel);
      for (int b = 0; b < 8; b++) m_bin[sel][b] = 0;
      m_zero[sel] = 0;
      m_win[sel]  = 0;
   endtask

   // Turn the model's finished window into one scoreboard entry per bin.
   task automatic pushExpected(input int sel);
      exp_t e;
      for (int b = 0; b < nBins(sel); b++) begin
         e.idx  = b;
         e.cnt  = m_bin[sel][b];
         e.last = (b == nBins(sel) - 1);
         e.zero = m_zero[sel];
         if (sel == 0) q0.push_back(e);
         else          q1.push_back(e);
      end
      resetModel(sel);
   endtask

   // Drive one sample for one cycle and update the model as if it was accepted.
   task automatic applyStimulus(input int sel, input int idx, input bit nz);
      int b;
      if (sel == 0) begin
         smp_valid = 1'b1; smp_index = 3'(idx); smp_nonzero = nz;
         checkOutput("smp_ready", smp_ready, 1);
      end else begin
         smp_valid2 = 1'b1; smp_index2 = 3'(idx); smp_nonzero2 = nz;
         checkOutput("smp_ready_sat", smp_ready2, 1);
      end
      @(posedge clk); #1;
      smp_valid  = 1'b0;
      smp_valid2 = 1'b0;
      m_win[sel]++;
      if (nz) begin
         b = (idx > nBins(sel) - 1) ? nBins(sel) - 1 : idx;
         if (m_bin[sel][b] < cntMax(sel)) m_bin[sel][b]++;
      end else begin
         m_zero[sel]++;
      end
      if (m_win[sel] == 16) pushExpected(sel);
   endtask

   task automatic sendWindow(input int sel, input int idx, input bit nz, input int count);
      for (int i = 0; i < count; i++) applyStimulus(sel, idx, nz);
   endtask

   // Wait (bounded) for the dump to finish, then check its length and the return to ACCUM.
   task automatic waitDrain(input int sel, input int exp_cycles, input string tag);
      int n = 0;
      while (((sel == 0) ? bin_valid : bin_valid2) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput({tag, "_drain_cycles"}, n, exp_cycles);
      checkOutput({tag, "_queue_left"}, (sel == 0) ? q0.size() : q1.size(), 0);
      checkOutput({tag, "_ready_after"}, (sel == 0) ? smp_ready : smp_ready2, 1);
   endtask

   // Scoreboard monitor for the main instance: compare each consumed bin.
   always @(negedge clk) begin
      if (arstn && cg && !clear && bin_valid && bin_ready) begin
         if (q0.size() == 0) begin
            checkOutput("bin_unexpected", 1, 0);
         end else begin
            e0 = q0.pop_front();
            checkOutput("bin_index", bin_index, e0.idx);
            checkOutput("bin_count", bin_count, e0.cnt);
            checkOutput("bin_last", bin_last, e0.last);
            checkOutput("zero_count", zero_count, e0.zero);
            checkOutput("smp_ready_in_dump", smp_ready, 0);
         end
      end
   end

   // Scoreboard monitor for the saturation/clamp instance.
   always @(negedge clk) begin
      if (arstn && bin_valid2 && bin_ready2) begin
         if (q1.size() == 0) begin
            checkOutput("sat_bin_unexpected", 1, 0);
         end else begin
            e1 = q1.pop_front();
            checkOutput("sat_bin_index", bin_index2, e1.idx);
            checkOutput("sat_bin_count", bin_count2, e1.cnt);
            checkOutput("sat_bin_last", bin_last2, e1.last);
            checkOutput("sat_zero_count", zero_count2, e1.zero);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      arstn = 1'b0; cg = 1'b1; clear = 1'b0;
      smp_valid = 1'b0; smp_index = '0; smp_nonzero = 1'b0; bin_ready = 1'b1;
      smp_valid2 = 1'b0; smp_index2 = '0; smp_nonzero2 = 1'b0; bin_ready2 = 1'b1;
      resetModel(0);
      resetModel(1);
      #12;
      checkOutput("rst_smp_ready", smp_ready, 1);
      checkOutput("rst_bin_valid", bin_valid, 0);
      checkOutput("rst_bin_index", bin_index, 0);
      checkOutput("rst_bin_count", bin_count, 0);
      checkOutput("rst_bin_last", bin_last, 0);
      checkOutput("rst_zero_count", zero_count, 0);
      @(negedge clk); arstn = 1'b1;
      @(posedge clk); #1;

      $display("[TB] single-index window");
      sendWindow(0, 3, 1'b1, 16);
      checkOutput("lat_bin_valid", bin_valid, 1);
      checkOutput("lat_bin_index", bin_index, 0);
      checkOutput("lat_smp_ready", smp_ready, 0);
      waitDrain(0, 8, "basic");

      $display("[TB] mixed window");
      sendWindow(0, 0, 1'b1, 4);
      sendWindow(0, 7, 1'b1, 6);
      sendWindow(0, 6, 1'b1, 2);
      sendWindow(0, 0, 1'b0, 4);
      waitDrain(0, 8, "mixed");

      $display("[TB] backpressure");
      bin_ready = 1'b0;
      sendWindow(0, 2, 1'b1, 16);
      bin_ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      bin_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_index", bin_index, 2);
         checkOutput("stall_count", bin_count, 16);
         checkOutput("stall_valid", bin_valid, 1);
         checkOutput("stall_smp_ready", smp_ready, 0);
         @(posedge clk); #1;
      end
      bin_ready = 1'b1;
      waitDrain(0, 6, "bp");

      $display("[TB] saturation and clamping");
      sendWindow(1, 1, 1'b1, 16);
      waitDrain(1, 5, "sat");
      sendWindow(1, 6, 1'b1, 2);
      sendWindow(1, 7, 1'b1, 3);
      sendWindow(1, 4, 1'b1, 1);
      sendWindow(1, 0, 1'b0, 10);
      waitDrain(1, 5, "clamp");

      $display("[TB] clear mid-window");
      sendWindow(0, 7, 1'b1, 10);
      clear = 1'b1; smp_valid = 1'b1; smp_index = 3'd7; smp_nonzero = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; smp_valid = 1'b0;
      resetModel(0);
      checkOutput("clr_zero_count", zero_count, 0);
      sendWindow(0, 5, 1'b1, 16);
      waitDrain(0, 8, "clr");

      $display("[TB] clear mid-dump");
      bin_ready = 1'b0;
      sendWindow(0, 3, 1'b1, 16);
      checkOutput("clrdump_pre_valid", bin_valid, 1);
      clear = 1'b1; bin_ready = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      q0.delete();
      checkOutput("clrdump_valid", bin_valid, 0);
      checkOutput("clrdump_smp_ready", smp_ready, 1);
      sendWindow(0, 0, 1'b0, 16);
      waitDrain(0, 8, "clrnext");

      $display("[TB] clock gate");
      cg = 1'b0; smp_valid = 1'b1; smp_index = 3'd1; smp_nonzero = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      smp_valid = 1'b0; cg = 1'b1;
      checkOutput("cg_zero_count", zero_count, 0);
      checkOutput("cg_smp_ready", smp_ready, 1);
      sendWindow(0, 2, 1'b1, 16);
      waitDrain(0, 8, "cg");

      $display("[TB] async reset mid-dump");
      bin_ready = 1'b0;
      sendWindow(0, 0, 1'b1, 16);
      checkOutput("ar_pre_count", bin_count, 16);
      @(negedge clk); #1;
      arstn = 1'b0;
      #1;
      checkOutput("ar_bin_valid", bin_valid, 0);
      checkOutput("ar_smp_ready", smp_ready, 1);
      checkOutput("ar_bin_index", bin_index, 0);
      checkOutput("ar_bin_count", bin_count, 0);
      checkOutput("ar_bin_last", bin_last, 0);
      checkOutput("ar_zero_count", zero_count, 0);
      q0.delete();
      resetModel(0);
      @(negedge clk); arstn = 1'b1;
      @(posedge clk); #1;
      bin_ready = 1'b1;
      sendWindow(0, 6, 1'b1, 16);
      waitDrain(0, 8, "ar");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
